// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback requests with per-slot visibility.
// Latency: push visible at head one cycle later.
// Backpressure: caller must not push when full or pop when empty.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_req_t                      push_dat,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output wb_req_t                      head,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][AW-1:0]     ent_addr
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  wb_req_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A push never targets the popped slot: push requires a free slot, pop an occupied one.
  always_comb begin
    vld_d = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_addr[i] = mem_q[i].addr;
  end

  assign head    = mem_q[rd_ptr_q];
  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign ent_vld = vld_q;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port: pipeline (A) first, buffered multi-cycle unit (B) in idle slots.
// Latency: request in cycle N drives rf_* in cycle N+1.
// Backpressure: A never held off; B via b_ready (= not full); starvation raises stall_req.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          pend_rs,
  output logic          pend_rt,
  output logic          stall_req,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  wb_req_t                   fifo_head, b_req;
  logic [DEPTH-1:0]          ent_vld;
  logic [DEPTH-1:0][AW-1:0]  ent_addr;
  logic                      b_fire, b_keep, bypass;

  logic                      rf_we_q, rf_we_d, src_b_q, src_b_d, stall_q, stall_d;
  logic [AW-1:0]             rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]             rf_wdata_q, rf_wdata_d;
  logic [WCW-1:0]            wait_q, wait_d;

  assign b_ready = rst_n & ~fifo_full;
  assign b_fire  = b_valid & b_ready;
  // Writes to r0 complete the handshake but are dropped here.
  assign b_keep  = b_fire & (b_waddr != REG_ZERO);
  assign b_req   = '{addr: b_waddr, data: b_wdata};

  assign fifo_pop  = ~a_we & ~fifo_empty;
  assign bypass    = ~a_we & fifo_empty & b_keep;
  assign fifo_push = b_keep & ~bypass;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (b_req),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    src_b_d    = 1'b0;
    if (a_we) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = a_waddr;
      rf_wdata_d = a_wdata;
    end else if (!fifo_empty) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_head.addr;
      rf_wdata_d = fifo_head.data;
      src_b_d    = 1'b1;
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = b_waddr;
      rf_wdata_d = b_wdata;
      src_b_d    = 1'b1;
    end
  end

  // Counter saturates at its last value so a stall ignored by the pipeline re-fires.
  always_comb begin
    wait_d  = '0;
    stall_d = 1'b0;
    if (!fifo_empty && !fifo_pop) begin
      wait_d  = (wait_q == WAIT_LAST) ? wait_q : wait_q + 1'b1;
      stall_d = (wait_q == WAIT_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      src_b_q    <= 1'b0;
      stall_q    <= 1'b0;
      wait_q     <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      src_b_q    <= src_b_d;
      stall_q    <= stall_d;
      wait_q     <= wait_d;
    end
  end

  always_comb begin
    pend_rs = rf_we_q & src_b_q & (rf_waddr_q == rs);
    pend_rt = rf_we_q & src_b_q & (rf_waddr_q == rt);
    for (int i = 0; i < DEPTH; i++) begin
      pend_rs = pend_rs | (ent_vld[i] & (ent_addr[i] == rs));
      pend_rt = pend_rt | (ent_vld[i] & (ent_addr[i] == rt));
    end
    pend_rs = pend_rs & (rs != REG_ZERO);
    pend_rt = pend_rt & (rt != REG_ZERO);
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_q;

  // The pipeline is expected to honour a stall by idling port A the next cycle.
  a_idle_on_stall: assert property (@(posedge clk) disable iff (!rst_n) stall_req |-> !a_we);
endmodule
